// File: rtl/revanth_sub_pkg.sv
// ============================================================================
// revanth_sub_pkg : shared types and constants for the subtract scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package revanth_sub_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int OPW       = 4;
  localparam int RESW      = 5;
  localparam int TAGW      = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Zero-extended difference; bit 4 becomes the borrow when a < b.
  function automatic logic [RESW-1:0] sub_borrow(input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/revanth_sub_if.sv
// ============================================================================
// revanth_sub_if : operand-queue bus and TinyTapeout pin bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface revanth_sub_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          clear;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  modport master (output push, pop, clear, wdata,
                  input  rdata, full, empty, count);
  modport slave  (input  push, pop, clear, wdata,
                  output rdata, full, empty, count);
endinterface

interface revanth_sub_pins_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport dut (input  ui_in, uio_in, ena,
               output uo_out, uio_out, uio_oe);
  modport tb  (output ui_in, uio_in, ena,
               input  uo_out, uio_out, uio_oe);
endinterface

`default_nettype wire

// File: rtl/revanth_sub_fifo.sv
// ============================================================================
// revanth_sub_fifo : DEPTH x 8 circular operand queue with count/full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module revanth_sub_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  revanth_sub_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign bus.full  = (count_q == CW'(DEPTH));
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;
  assign bus.rdata = mem_q[rd_ptr_q];

  assign do_push = bus.push & ~bus.full & ~bus.clear;
  assign do_pop  = bus.pop  & ~bus.empty & ~bus.clear;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.wdata;
  end

endmodule

`default_nettype wire

// File: rtl/tt_um_revanth_sub_sched.sv
// ============================================================================
// tt_um_revanth_sub_sched : queued 4-bit subtractor with valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module tt_um_revanth_sub_sched
  import revanth_sub_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  wire logic [7:0] ui_in,
  output wire logic [7:0] uo_out,
  input  wire logic [7:0] uio_in,
  output wire logic [7:0] uio_out,
  output wire logic [7:0] uio_oe,
  input  wire logic       ena,
  input  wire logic       clk,
  input  wire logic       rst_n
);

  revanth_sub_fifo_if #(.DEPTH(DEPTH)) fifo_bus ();

  revanth_sub_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fifo_bus)
  );

  state_e          state_q;
  logic [7:0]      op_q;
  logic [TAGW-1:0] op_tag_q;
  logic [RESW-1:0] res_q;
  logic [TAGW-1:0] tag_q;
  logic            zero_q;
  logic [TAGW-1:0] tag_cnt_q;
  logic            ovf_q;

  logic            push_w;
  logic            ready_w;
  logic            clear_w;
  logic            in_ready_w;
  logic            pop_w;
  logic [TAGW-1:0] head_tag_w;
  logic            unused_ok;

  assign push_w     = uio_in[0];
  assign ready_w    = uio_in[1];
  assign clear_w    = uio_in[2];
  assign in_ready_w = ~fifo_bus.full;

  // Entries leave in order, so the head's tag is the accept counter minus occupancy.
  assign head_tag_w = tag_cnt_q - fifo_bus.count[TAGW-1:0];

  assign pop_w = ~clear_w & ~fifo_bus.empty &
                 ((state_q == S_IDLE) | ((state_q == S_HOLD) & ready_w));

  assign fifo_bus.push  = push_w & in_ready_w & ~clear_w;
  assign fifo_bus.pop   = pop_w;
  assign fifo_bus.clear = clear_w;
  assign fifo_bus.wdata = ui_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      op_tag_q  <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      zero_q    <= 1'b0;
      tag_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (clear_w) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      op_tag_q  <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      zero_q    <= 1'b0;
      tag_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_w && in_ready_w)  tag_cnt_q <= tag_cnt_q + 1'b1;
      if (push_w && !in_ready_w) ovf_q     <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (pop_w) begin
            op_q     <= fifo_bus.rdata;
            op_tag_q <= head_tag_w;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= sub_borrow(op_q[OPW-1:0], op_q[2*OPW-1:OPW]);
          zero_q  <= (op_q[OPW-1:0] == op_q[2*OPW-1:OPW]);
          tag_q   <= op_tag_q;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (ready_w) begin
            if (pop_w) begin
              op_q     <= fifo_bus.rdata;
              op_tag_q <= head_tag_w;
              state_q  <= S_EXEC;
            end else begin
              state_q  <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = {zero_q, tag_q, res_q};
  assign uio_out = {fifo_bus.empty, (state_q != S_IDLE), ovf_q,
                    (state_q == S_HOLD), in_ready_w, 3'b000};
  assign uio_oe  = 8'b1111_1000;

  assign unused_ok = &{1'b0, ena, uio_in[7:3], fifo_bus.count};

endmodule

`default_nettype wire
